// File: rtl/mem_request_arbiter_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : mem_request_arbiter_pkg                                    |
// | Description : Shared CPU memory types plus arbiter state/port encodings  |
// |               and the port-selection helper used on every grant.         |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
package mem_request_arbiter_pkg;

  localparam int c_WORD_W = 32;

  typedef logic [c_WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IREQ = 2'd1,
    DREQ = 2'd2,
    ERR  = 2'd3
  } arb_state_t;

  typedef enum logic {
    INSTR = 1'b0,
    DATA  = 1'b1
  } arb_port_t;

  // With both ports pending the one not served last wins; otherwise the
  // single pending port wins. Only meaningful when at least one is pending.
  function automatic arb_port_t pick_port(input logic      ipend,
                                          input logic      dpend,
                                          input arb_port_t last);
    arb_port_t port;
    port = INSTR;
    if (dpend && (!ipend || (last == INSTR))) begin
      port = DATA;
    end
    return port;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_request_arbiter_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : mem_request_arbiter_if                                     |
// | Description : CPU request ports and RAM bus seen by the memory arbiter.  |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
interface mem_request_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int WORD_W = 32
);
  import mem_request_arbiter_pkg::*;

  // instruction port
  logic              iREN;
  logic [ADDR_W-1:0] iaddr;
  logic [WORD_W-1:0] iload;
  logic              iwait;
  // data port
  logic              dREN;
  logic              dWEN;
  logic [ADDR_W-1:0] daddr;
  logic [WORD_W-1:0] dstore;
  logic [WORD_W-1:0] dload;
  logic              dwait;
  logic              halt;
  // RAM side
  logic              ramREN;
  logic              ramWEN;
  logic [ADDR_W-1:0] ramaddr;
  logic [WORD_W-1:0] ramstore;
  logic [WORD_W-1:0] ramload;
  ramstate_t         ramstate;
  logic              err;

  // arbiter side
  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, halt, ramload, ramstate,
    output iload, iwait, dload, dwait, ramREN, ramWEN, ramaddr, ramstore, err
  );

  // requester / RAM-model side
  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, halt, ramload, ramstate,
    input  iload, iwait, dload, dwait, ramREN, ramWEN, ramaddr, ramstore, err
  );

endinterface
`default_nettype wire

// File: rtl/mem_request_arbiter_access_timer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : access_timer                                               |
// | Description : Counts grant cycles without ACCESS; flags the cycle whose  |
// |               count would bring the timer to TIMEOUT-1.                  |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module access_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_count,
  output logic o_expired
);

  localparam int              c_TW    = (TIMEOUT <= 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [c_TW-1:0] c_LIMIT = c_TW'(TIMEOUT - 2);

  logic [c_TW-1:0] r_timer;

  // Waiting-cycle counter; cleared on completion and whenever no grant is open.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_timer <= '0;
    end else if (i_clear) begin
      r_timer <= '0;
    end else if (i_count) begin
      r_timer <= r_timer + 1'b1;
    end
  end

  // Expiry is seen one cycle early so the FSM enters ERR exactly as the
  // timer reaches TIMEOUT-1.
  assign o_expired = i_count && (r_timer == c_LIMIT);

endmodule
`default_nettype wire

// File: rtl/mem_request_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : mem_request_arbiter                                        |
// | Description : Arbitrates instruction and data requests onto a single-    |
// |               ported RAM, one transaction at a time, with fairness,      |
// |               grant latching, timeout and sticky error reporting.        |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module mem_request_arbiter
  import mem_request_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int WORD_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                 CLK,
  input  logic                 nRST,
  mem_request_arbiter_if.slave bus
);

  arb_state_t        r_state;
  arb_state_t        w_state_next;
  arb_port_t         r_last;
  arb_port_t         w_last_next;
  arb_port_t         w_grant_port;
  arb_port_t         w_serving;
  logic              r_wr;
  logic [ADDR_W-1:0] r_addr;
  logic [WORD_W-1:0] r_data;
  logic              w_ipend;
  logic              w_dpend;
  logic              w_in_grant;
  logic              w_access;
  logic              w_grant;
  logic              w_expired;
  logic              w_tmr_clear;
  logic              w_tmr_count;

  assign w_ipend     = bus.iREN && !bus.halt;
  assign w_dpend     = bus.dREN || bus.dWEN;
  assign w_in_grant  = (r_state == IREQ) || (r_state == DREQ);
  assign w_access    = (bus.ramstate == ACCESS);
  assign w_serving   = (r_state == DREQ) ? DATA : INSTR;
  assign w_tmr_clear = !w_in_grant || w_access;
  assign w_tmr_count = w_in_grant && !w_access;

  access_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_access_timer (
    .clk       (CLK),
    .rst_n     (nRST),
    .i_clear   (w_tmr_clear),
    .i_count   (w_tmr_count),
    .o_expired (w_expired)
  );

  // FSM state and fairness history register.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= IDLE;
      r_last  <= INSTR;
    end else begin
      r_state <= w_state_next;
      r_last  <= w_last_next;
    end
  end

  // Next-state logic: grant from IDLE, or chain straight into the next
  // grant on completion so back-to-back accesses need no IDLE bubble.
  always_comb begin
    w_state_next = r_state;
    w_last_next  = r_last;
    w_grant      = 1'b0;
    w_grant_port = INSTR;
    case (r_state)
      IDLE: begin
        if (w_ipend || w_dpend) begin
          w_grant      = 1'b1;
          w_grant_port = pick_port(w_ipend, w_dpend, r_last);
          w_state_next = (w_grant_port == DATA) ? DREQ : IREQ;
        end
      end
      IREQ, DREQ: begin
        if ((bus.ramstate == ERROR) || w_expired) begin
          w_state_next = ERR;
        end else if (w_access) begin
          w_last_next = w_serving;
          if (w_ipend || w_dpend) begin
            w_grant      = 1'b1;
            w_grant_port = pick_port(w_ipend, w_dpend, w_serving);
            w_state_next = (w_grant_port == DATA) ? DREQ : IREQ;
          end else begin
            w_state_next = IDLE;
          end
        end
      end
      ERR: begin
        w_state_next = ERR;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Grant latches: the RAM is driven only from these, so request-side
  // changes after the grant edge cannot disturb an access in flight.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_wr   <= 1'b0;
      r_addr <= '0;
      r_data <= '0;
    end else if (w_grant) begin
      r_addr <= (w_grant_port == DATA) ? bus.daddr : bus.iaddr;
      r_data <= bus.dstore;
      r_wr   <= (w_grant_port == DATA) && bus.dWEN;
    end
  end

  assign bus.ramREN   = w_in_grant && !r_wr;
  assign bus.ramWEN   = w_in_grant && r_wr;
  assign bus.ramaddr  = r_addr;
  assign bus.ramstore = r_data;
  assign bus.iwait    = !((r_state == IREQ) && w_access);
  assign bus.dwait    = !((r_state == DREQ) && w_access);
  assign bus.iload    = bus.ramload;
  assign bus.dload    = bus.ramload;
  assign bus.err      = (r_state == ERR);

endmodule
`default_nettype wire

// File: tb/tb_mem_request_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_mem_request_arbiter                                     |
// | Description : Self-checking bench: directed vector table, hand-written   |
// |               timeout/error/reset sequences, random traffic vs. model.   |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_mem_request_arbiter;
  import mem_request_arbiter_pkg::*;

  localparam int TIMEOUT = 16;

  logic CLK  = 1'b0;
  logic nRST = 1'b0;

  mem_request_arbiter_if #(.ADDR_W(32), .WORD_W(32)) bus ();

  mem_request_arbiter #(
    .ADDR_W  (32),
    .WORD_W  (32),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic iren, input logic dren, input logic dwen, input logic hlt,
                       input logic [31:0] ia, input logic [31:0] da, input logic [31:0] ds,
                       input ramstate_t rs, input logic [31:0] rl);
    bus.iREN = iren; bus.dREN = dren; bus.dWEN = dwen; bus.halt = hlt;
    bus.iaddr = ia; bus.daddr = da; bus.dstore = ds;
    bus.ramstate = rs; bus.ramload = rl;
  endtask

  // ---------------- reference model (transaction level) ----------------
  bit        m_act, m_err, m_wr;
  arb_port_t m_port, m_last;
  int        m_age;
  logic [31:0] m_addr, m_store;

  task automatic model_reset();
    m_act = 0; m_err = 0; m_wr = 0; m_port = INSTR; m_last = INSTR;
    m_age = 0; m_addr = 0; m_store = 0;
  endtask

  task automatic model_check();
    logic er, ew, eiw, edw, ee;
    er = 0; ew = 0; eiw = 1; edw = 1; ee = m_err;
    if (!m_err && m_act) begin
      er = !m_wr; ew = m_wr;
      if (bus.ramstate == ACCESS) begin
        if (m_port == INSTR) eiw = 0; else edw = 0;
      end
    end
    check("rnd ramREN", 32'(bus.ramREN), 32'(er));
    check("rnd ramWEN", 32'(bus.ramWEN), 32'(ew));
    check("rnd iwait",  32'(bus.iwait),  32'(eiw));
    check("rnd dwait",  32'(bus.dwait),  32'(edw));
    check("rnd err",    32'(bus.err),    32'(ee));
    if (!m_err && m_act) check("rnd ramaddr", bus.ramaddr, m_addr);
    if (!m_err && m_act && m_wr) check("rnd ramstore", bus.ramstore, m_store);
    if (!eiw) check("rnd iload", bus.iload, bus.ramload);
    if (!edw) check("rnd dload", bus.dload, bus.ramload);
  endtask

  task automatic model_step();
    bit ip, dp;
    arb_port_t w;
    ip = bus.iREN && !bus.halt;
    dp = bus.dREN || bus.dWEN;
    if (!m_err) begin
      if (m_act) begin
        if (bus.ramstate == ERROR) m_err = 1;
        else if (bus.ramstate == ACCESS) begin
          m_last = m_port;
          m_act  = 0;
        end else begin
          m_age++;
          if (m_age == TIMEOUT - 1) m_err = 1;
        end
      end
      if (!m_err && !m_act && (ip || dp)) begin
        if (ip && dp) w = (m_last == INSTR) ? DATA : INSTR;
        else          w = dp ? DATA : INSTR;
        m_act   = 1;
        m_port  = w;
        m_age   = 0;
        m_wr    = (w == DATA) && bus.dWEN;
        m_addr  = (w == DATA) ? bus.daddr : bus.iaddr;
        m_store = bus.dstore;
      end
    end
  endtask

  task automatic do_reset(input bit check_vals);
    drive(0, 0, 0, 0, 0, 0, 0, FREE, 0);
    @(negedge CLK);
    nRST = 1'b0;
    repeat (2) @(negedge CLK);
    if (check_vals) begin
      check("reset ramREN",   32'(bus.ramREN), 0);
      check("reset ramWEN",   32'(bus.ramWEN), 0);
      check("reset ramaddr",  bus.ramaddr, 0);
      check("reset ramstore", bus.ramstore, 0);
      check("reset iwait",    32'(bus.iwait), 1);
      check("reset dwait",    32'(bus.dwait), 1);
      check("reset err",      32'(bus.err), 0);
    end
    nRST = 1'b1;
    model_reset();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        iren, dren, dwen, hlt;
    logic [31:0] ia, da, ds;
    ramstate_t   rs;
    logic [31:0] rl;
    logic        e_ren, e_wen;
    logic [31:0] e_addr;
    logic        e_iw, e_dw;
    logic [31:0] e_store;
  } vec_t;

  function automatic vec_t v(logic iren, logic dren, logic dwen, logic hlt,
                             logic [31:0] ia, logic [31:0] da, logic [31:0] ds,
                             ramstate_t rs, logic [31:0] rl,
                             logic e_ren, logic e_wen, logic [31:0] e_addr,
                             logic e_iw, logic e_dw, logic [31:0] e_store);
    vec_t r;
    r.iren = iren; r.dren = dren; r.dwen = dwen; r.hlt = hlt;
    r.ia = ia; r.da = da; r.ds = ds; r.rs = rs; r.rl = rl;
    r.e_ren = e_ren; r.e_wen = e_wen; r.e_addr = e_addr;
    r.e_iw = e_iw; r.e_dw = e_dw; r.e_store = e_store;
    return r;
  endfunction

  vec_t vecs[$];

  initial begin
    int acc_pct[5] = '{60, 80, 40, 8, 95};

    // instruction read, ACCESS at cycle 2
    vecs.push_back(v(1,0,0,0, 32'h40,0,0, FREE,0,               0,0,0,     1,1,0));
    vecs.push_back(v(0,0,0,0, 32'h40,0,0, BUSY,0,               1,0,32'h40,1,1,0));
    vecs.push_back(v(0,0,0,0, 32'h40,0,0, ACCESS,32'h00A00093,  1,0,32'h40,0,1,0));
    vecs.push_back(v(0,0,0,0, 0,0,0,      FREE,0,               0,0,0,     1,1,0));
    // simultaneous iREN & dWEN: write first, then instruction
    vecs.push_back(v(1,0,1,0, 32'h100,32'h80,32'hDEADBEEF, ACCESS,0,      0,0,0,      1,1,0));
    vecs.push_back(v(1,0,0,0, 32'h100,32'h80,32'hDEADBEEF, ACCESS,32'h11, 0,1,32'h80, 1,0,32'hDEADBEEF));
    vecs.push_back(v(0,0,0,0, 32'h100,0,0, ACCESS,32'h22,       1,0,32'h100,0,1,0));
    vecs.push_back(v(0,0,0,0, 0,0,0,       FREE,0,              0,0,0,      1,1,0));
    // fairness: D,I,D,I
    vecs.push_back(v(1,1,0,0, 32'h300,32'h200,0, ACCESS,0,      0,0,0,      1,1,0));
    vecs.push_back(v(1,1,0,0, 32'h300,32'h200,0, ACCESS,32'h33, 1,0,32'h200,1,0,0));
    vecs.push_back(v(1,1,0,0, 32'h300,32'h200,0, ACCESS,32'h44, 1,0,32'h300,0,1,0));
    vecs.push_back(v(1,1,0,0, 32'h300,32'h200,0, ACCESS,32'h45, 1,0,32'h200,1,0,0));
    vecs.push_back(v(0,0,0,0, 32'h300,32'h200,0, ACCESS,32'h55, 1,0,32'h300,0,1,0));
    // address change mid-grant is ignored
    vecs.push_back(v(1,0,0,0, 32'h40,0,0, FREE,0,               0,0,0,     1,1,0));
    vecs.push_back(v(1,0,0,0, 32'h44,0,0, BUSY,0,               1,0,32'h40,1,1,0));
    vecs.push_back(v(0,0,0,0, 32'h44,0,0, BUSY,0,               1,0,32'h40,1,1,0));
    vecs.push_back(v(0,0,0,0, 32'h44,0,0, ACCESS,32'h66,        1,0,32'h40,0,1,0));
    // halt blocks instruction grants
    vecs.push_back(v(1,0,0,1, 32'h48,0,0, ACCESS,0,             0,0,0,     1,1,0));
    vecs.push_back(v(1,0,0,1, 32'h48,0,0, ACCESS,0,             0,0,0,     1,1,0));
    // dWEN beats dREN; dstore latched at grant
    vecs.push_back(v(0,1,1,0, 0,32'h84,32'h12345678, FREE,0,    0,0,0,     1,1,0));
    vecs.push_back(v(0,0,0,0, 0,32'h84,0, ACCESS,32'h77,        0,1,32'h84,1,0,32'h12345678));
    vecs.push_back(v(0,0,0,0, 0,0,0,      FREE,0,               0,0,0,     1,1,0));

    do_reset(1);
    foreach (vecs[k]) begin
      @(posedge CLK); #1;
      drive(vecs[k].iren, vecs[k].dren, vecs[k].dwen, vecs[k].hlt,
            vecs[k].ia, vecs[k].da, vecs[k].ds, vecs[k].rs, vecs[k].rl);
      @(negedge CLK);
      check($sformatf("vec%0d ramREN", k), 32'(bus.ramREN), 32'(vecs[k].e_ren));
      check($sformatf("vec%0d ramWEN", k), 32'(bus.ramWEN), 32'(vecs[k].e_wen));
      check($sformatf("vec%0d iwait", k),  32'(bus.iwait),  32'(vecs[k].e_iw));
      check($sformatf("vec%0d dwait", k),  32'(bus.dwait),  32'(vecs[k].e_dw));
      check($sformatf("vec%0d err", k),    32'(bus.err),    0);
      if (vecs[k].e_ren || vecs[k].e_wen)
        check($sformatf("vec%0d ramaddr", k), bus.ramaddr, vecs[k].e_addr);
      if (vecs[k].e_wen)
        check($sformatf("vec%0d ramstore", k), bus.ramstore, vecs[k].e_store);
      if (!vecs[k].e_iw) check($sformatf("vec%0d iload", k), bus.iload, vecs[k].rl);
      if (!vecs[k].e_dw) check($sformatf("vec%0d dload", k), bus.dload, vecs[k].rl);
    end

    // timeout: BUSY forever after a data read grant
    do_reset(0);
    @(posedge CLK); #1; drive(0,1,0,0, 0,32'h500,0, BUSY,0);
    @(negedge CLK); check("to grant-edge ramREN", 32'(bus.ramREN), 0);
    for (int c = 1; c <= 15; c++) begin
      @(posedge CLK); #1; drive(0,0,0,0, 0,0,0, BUSY,0);
      @(negedge CLK);
      check($sformatf("to c%0d ramREN", c), 32'(bus.ramREN), 1);
      check($sformatf("to c%0d err", c), 32'(bus.err), 0);
    end
    @(posedge CLK); #1;
    @(negedge CLK);
    check("to c16 err",    32'(bus.err), 1);
    check("to c16 ramREN", 32'(bus.ramREN), 0);
    check("to c16 ramWEN", 32'(bus.ramWEN), 0);
    check("to c16 dwait",  32'(bus.dwait), 1);
    for (int c = 0; c < 3; c++) begin
      @(posedge CLK); #1; drive(1,0,0,0, 32'h40,0,0, ACCESS,0);
      @(negedge CLK);
      check("to sticky err",    32'(bus.err), 1);
      check("to sticky ramREN", 32'(bus.ramREN), 0);
      check("to sticky iwait",  32'(bus.iwait), 1);
    end

    // ramstate ERROR during a grant
    do_reset(0);
    @(posedge CLK); #1; drive(0,1,0,0, 0,32'h520,0, FREE,0);
    @(posedge CLK); #1; drive(0,0,0,0, 0,0,0, ERROR,0);
    @(negedge CLK);
    check("rerr same-cycle err", 32'(bus.err), 0);
    check("rerr ramREN",         32'(bus.ramREN), 1);
    @(posedge CLK); #1; drive(0,0,0,0, 0,0,0, FREE,0);
    @(negedge CLK);
    check("rerr next err",    32'(bus.err), 1);
    check("rerr next ramREN", 32'(bus.ramREN), 0);

    // async reset mid-grant, then halt blocks instruction grants
    do_reset(0);
    @(posedge CLK); #1; drive(0,0,1,0, 0,32'h600,32'hCAFE, BUSY,0);
    @(posedge CLK); #1; drive(0,0,0,0, 0,0,0, BUSY,0);
    check("rst pre ramWEN", 32'(bus.ramWEN), 1);
    #1; nRST = 1'b0;
    #1;
    check("rst async ramWEN", 32'(bus.ramWEN), 0);
    check("rst async ramREN", 32'(bus.ramREN), 0);
    check("rst async err",    32'(bus.err), 0);
    drive(1,0,0,1, 32'h700,0,0, ACCESS,0);
    @(negedge CLK); nRST = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      check("halt ramREN", 32'(bus.ramREN), 0);
      check("halt iwait",  32'(bus.iwait), 1);
    end
    bus.halt = 1'b0;
    @(negedge CLK);
    check("unhalt ramREN",  32'(bus.ramREN), 1);
    check("unhalt ramaddr", bus.ramaddr, 32'h700);
    check("unhalt iwait",   32'(bus.iwait), 0);

    // random traffic against the model
    for (int e = 0; e < 5; e++) begin
      do_reset(0);
      for (int c = 0; c < 300; c++) begin
        int r;
        ramstate_t rs;
        @(posedge CLK); #1;
        r = $urandom_range(0, 999);
        if (r < 5)                    rs = ERROR;
        else if (r < acc_pct[e] * 10) rs = ACCESS;
        else if (r < 800)             rs = BUSY;
        else                          rs = FREE;
        drive($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 30,
              $urandom_range(0, 99) < 20, $urandom_range(0, 99) < 10,
              $urandom, $urandom, $urandom, rs, $urandom);
        @(negedge CLK);
        model_check();
        model_step();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
